matrix_det_engine: RTL and testbench

Streaming signed-determinant engine for 2x2 or 3x3 matrices, selectable per matrix, with parametrised element and result widths. Elements arrive row-major over a valid/ready handshake. The determinant is computed sequentially, one Sarrus/cofactor product term per cycle, through a single shared 3-operand multiplier. The result is saturated to the output width, flagged on overflow, and held until the downstream consumer accepts it.

---
 rtl/matrix_det_pkg.sv | 80 ++++++++
 rtl/matrix_det_sat.sv | 37 +++
 rtl/matrix_det_engine.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_det_engine.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_det_pkg.sv
// matrix_det_pkg: shared types, term tables and helpers for the streaming
// determinant engine.
//   state_e      : engine FSM states (LOAD, CALC, OUT)
//   mode_e       : matrix size (2x2 or 3x3)
//   term_t       : one product term: sign plus three flat operand indices
//   term_lookup  : term table for both modes
//   term_last    : index of the final term for a mode
//   acc_width    : default accumulator width for a given element width
//   sat_max/min  : signed saturation limits for a w-bit result
package matrix_det_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    typedef enum logic {
        M2X2 = 1'b0,
        M3X3 = 1'b1
    } mode_e;

    // Wide enough for any realistic limit computation.
    localparam int LIMIT_W = 128;

    // Matrix storage is flat, index = row*3 + col, for both sizes.
    // IDX_ONE is not a storage slot: it selects the constant 1 operand.
    localparam logic [3:0] IDX_ONE = 4'd15;

    typedef struct packed {
        logic       neg;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } term_t;

    function automatic int acc_width(input int data_w);
        return 3 * data_w + 3;
    endfunction

    function automatic logic signed [LIMIT_W-1:0] sat_max(input int w);
        logic signed [LIMIT_W-1:0] one;
        one = {{(LIMIT_W-1){1'b0}}, 1'b1};
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [LIMIT_W-1:0] sat_min(input int w);
        logic signed [LIMIT_W-1:0] one;
        one = {{(LIMIT_W-1){1'b0}}, 1'b1};
        return -(one <<< (w - 1));
    endfunction

    // 2x2: +a00*a11, -a01*a10 (third operand constant 1).
    // 3x3: Sarrus, three positive diagonals then three negative ones.
    function automatic term_t term_lookup(input mode_e m, input logic [2:0] k);
        term_t t;
        t = '{neg: 1'b0, a: 4'd0, b: 4'd4, c: IDX_ONE};
        if (m == M2X2) begin
            case (k)
                3'd0:    t = '{neg: 1'b0, a: 4'd0, b: 4'd4, c: IDX_ONE};
                default: t = '{neg: 1'b1, a: 4'd1, b: 4'd3, c: IDX_ONE};
            endcase
        end else begin
            case (k)
                3'd0:    t = '{neg: 1'b0, a: 4'd0, b: 4'd4, c: 4'd8};
                3'd1:    t = '{neg: 1'b0, a: 4'd1, b: 4'd5, c: 4'd6};
                3'd2:    t = '{neg: 1'b0, a: 4'd2, b: 4'd3, c: 4'd7};
                3'd3:    t = '{neg: 1'b1, a: 4'd2, b: 4'd4, c: 4'd6};
                3'd4:    t = '{neg: 1'b1, a: 4'd0, b: 4'd5, c: 4'd7};
                default: t = '{neg: 1'b1, a: 4'd1, b: 4'd3, c: 4'd8};
            endcase
        end
        return t;
    endfunction

    function automatic logic [2:0] term_last(input mode_e m);
        return (m == M3X3) ? 3'd5 : 3'd1;
    endfunction

endpackage

// File: rtl/matrix_det_sat.sv
// matrix_det_sat: combinational signed saturator from the accumulator width
// down to the determinant width.
//   acc_in  : ACC_W two's-complement value
//   det_out : DET_W value, clamped to the signed DET_W range
//   ovf     : high when acc_in lies outside that range
module matrix_det_sat
    import matrix_det_pkg::*;
#(
    parameter int ACC_W = 51,
    parameter int DET_W = 16
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [DET_W-1:0] det_out,
    output logic             ovf
);

    localparam logic signed [LIMIT_W-1:0] MAX_L = sat_max(DET_W);
    localparam logic signed [LIMIT_W-1:0] MIN_L = sat_min(DET_W);
    localparam logic signed [ACC_W-1:0]   MAX_A = MAX_L[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0]   MIN_A = MIN_L[ACC_W-1:0];

    logic signed [ACC_W-1:0] acc_s;
    assign acc_s = $signed(acc_in);

    always_comb begin
        det_out = acc_in[DET_W-1:0];
        ovf     = 1'b0;
        if (acc_s > MAX_A) begin
            det_out = MAX_L[DET_W-1:0];
            ovf     = 1'b1;
        end else if (acc_s < MIN_A) begin
            det_out = MIN_L[DET_W-1:0];
            ovf     = 1'b1;
        end
    end

endmodule

// File: rtl/matrix_det_engine.sv
// matrix_det_engine: streaming signed determinant of a 2x2 or 3x3 matrix.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mode_3x3    : size select, captured with the first element of a matrix
//   in_data     : matrix element, row-major
//   in_valid    : element present          in_ready : engine takes it
//   abort       : drop the current matrix or pending result
//   det         : saturated determinant    overflow : result was clamped
//   det_valid   : result present           det_ready: consumer takes it
//   busy        : computing, or partway through loading a matrix
//   dbg_state   : current FSM state (state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in LOAD. Output side:
// det_valid is high only in OUT; det/overflow are stable until det_ready.
// abort overrides both handshakes in the same cycle.
module matrix_det_engine
    import matrix_det_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DET_W  = 16,
    parameter int ACC_W  = 3 * DATA_W + 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_3x3,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [DET_W-1:0]  det,
    output logic              det_valid,
    input  logic              det_ready,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PROD_W = 3 * DATA_W;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [3:0]        elem_cnt_q, elem_cnt_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [2:0]        term_idx_q, term_idx_d;
    logic [DET_W-1:0]  det_q, det_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mat_q [0:8];
    logic              store_en;
    logic [3:0]        wr_idx;

    mode_e             cur_mode;
    term_t             term;
    logic [DATA_W-1:0] op_a, op_b, op_c;
    logic signed [PROD_W-1:0] a_x, b_x, c_x, prod;
    logic [ACC_W-1:0]  term_x, acc_sum;
    logic [DET_W-1:0]  sat_det;
    logic              sat_ovf;

    function automatic logic [DATA_W-1:0] op_val(input logic [3:0] idx);
        if (idx == IDX_ONE) begin
            return {{(DATA_W-1){1'b0}}, 1'b1};
        end
        return mat_q[idx];
    endfunction

    // Size comes from the input pin on the first element, then from the latch.
    assign cur_mode = (elem_cnt_q == 4'd0) ? mode_e'(mode_3x3) : mode_q;
    assign wr_idx   = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};

    // Shared multiplier: operands sign-extended to the full product width,
    // so the 3-way product is exact.
    assign term = term_lookup(mode_q, term_idx_q);
    assign op_a = op_val(term.a);
    assign op_b = op_val(term.b);
    assign op_c = op_val(term.c);
    assign a_x  = {{(PROD_W-DATA_W){op_a[DATA_W-1]}}, op_a};
    assign b_x  = {{(PROD_W-DATA_W){op_b[DATA_W-1]}}, op_b};
    assign c_x  = {{(PROD_W-DATA_W){op_c[DATA_W-1]}}, op_c};
    assign prod = a_x * b_x * c_x;
    assign term_x  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_sum = term.neg ? (acc_q - term_x) : (acc_q + term_x);

    matrix_det_sat #(
        .ACC_W (ACC_W),
        .DET_W (DET_W)
    ) u_sat (
        .acc_in  (acc_sum),
        .det_out (sat_det),
        .ovf     (sat_ovf)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        elem_cnt_d = elem_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        term_idx_d = term_idx_q;
        det_d      = det_q;
        ovf_d      = ovf_q;
        store_en   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid && !abort) begin
                    store_en   = 1'b1;
                    mode_d     = cur_mode;
                    elem_cnt_d = elem_cnt_q + 4'd1;
                    if (col_q == ((cur_mode == M3X3) ? 2'd2 : 2'd1)) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                    if (elem_cnt_q == ((cur_mode == M3X3) ? 4'd8 : 4'd3)) begin
                        state_d    = ST_CALC;
                        acc_d      = '0;
                        term_idx_d = 3'd0;
                        row_d      = 2'd0;
                        col_d      = 2'd0;
                    end
                end
            end
            ST_CALC: begin
                acc_d      = acc_sum;
                term_idx_d = term_idx_q + 3'd1;
                if (term_idx_q == term_last(mode_q)) begin
                    state_d = ST_OUT;
                    det_d   = sat_det;
                    ovf_d   = sat_ovf;
                end
            end
            ST_OUT: begin
                if (det_ready) begin
                    state_d    = ST_LOAD;
                    ovf_d      = 1'b0;
                    elem_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // abort wins over any handshake; the last reported det is kept.
        if (abort) begin
            state_d    = ST_LOAD;
            elem_cnt_d = 4'd0;
            row_d      = 2'd0;
            col_d      = 2'd0;
            ovf_d      = 1'b0;
            det_d      = det_q;
            store_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            mode_q     <= M2X2;
            elem_cnt_q <= 4'd0;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            acc_q      <= '0;
            term_idx_q <= 3'd0;
            det_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            elem_cnt_q <= elem_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            term_idx_q <= term_idx_d;
            det_q      <= det_d;
            ovf_q      <= ovf_d;
        end
    end

    // Element storage is not reset: every slot is rewritten before use.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mat_q[wr_idx] <= in_data;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign det_valid = (state_q == ST_OUT);
    assign det       = det_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ST_CALC) ||
                       ((state_q == ST_LOAD) && (elem_cnt_q != 4'd0));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_det_engine.sv
// tb_matrix_det_engine: directed checks of matrix_det_engine. Inputs are
// driven and outputs sampled on the falling edge of clk.
module tb_matrix_det_engine;

    logic        clk;
    logic        rst_n;
    logic        mode_3x3;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic [15:0] det;
    logic        det_valid;
    logic        det_ready;
    logic        overflow;
    logic        busy;
    logic [1:0]  dbg_state;

    int pass_cnt;
    int total_cnt;
    int mat_buf [9];

    matrix_det_engine #(
        .DATA_W (16),
        .DET_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_3x3  (mode_3x3),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .det       (det),
        .det_valid (det_valid),
        .det_ready (det_ready),
        .overflow  (overflow),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: present one element (optionally after a random idle gap) and
    // let the next rising edge take it.
    task automatic send_one(input logic [15:0] v, input logic m, input int gap_max);
        int guard;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        mode_3x3 = m;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (guard >= 100) $display("FAIL in_ready_wait: in_ready=%b, required 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_matrix(input logic m_first, input logic m_rest, input int n, input int gap_max);
        for (int i = 0; i < n * n; i++) begin
            send_one(16'(mat_buf[i]), (i == 0) ? m_first : m_rest, gap_max);
        end
    endtask

    // driver: wait for det_valid (bounded), capture, then accept.
    task automatic get_result(output int lat, output logic [15:0] d, output logic o);
        lat = 0;
        while (det_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = det;
        o = overflow;
        det_ready = 1'b1;
        @(negedge clk);
        det_ready = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({det, det_valid, overflow, busy, in_ready, dbg_state} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0})
            $display("FAIL reset_outputs: det=%h dv=%b ovf=%b busy=%b rdy=%b st=%0d, required 0000 0 0 0 1 0",
                     det, det_valid, overflow, busy, in_ready, dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_3x3_basic();
        int lat; logic [15:0] d; logic o;
        mat_buf = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
        det_ready = 1'b1;
        load_matrix(1'b1, 1'b1, 3, 0);
        total_cnt++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL calc_flags: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        else pass_cnt++;
        get_result(lat, d, o);
        total_cnt++;
        if (d !== 16'hFECE) $display("FAIL det_3x3: det=%h, required fece", d); else pass_cnt++;
        total_cnt++;
        if (o !== 1'b0) $display("FAIL ovf_3x3: overflow=%b, required 0", o); else pass_cnt++;
        total_cnt++;
        if (lat !== 6) $display("FAIL lat_3x3: latency=%0d, required 6", lat); else pass_cnt++;
        total_cnt++;
        if ({det_valid, in_ready} !== 2'b01) $display("FAIL after_accept: dv=%b rdy=%b, required 0 1", det_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_2x2();
        int lat; logic [15:0] d; logic o;
        mat_buf = '{3, 8, 4, 6, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'hFFF2, 1'b0}) $display("FAIL det_2x2: det=%h ovf=%b, required fff2 0", d, o); else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL lat_2x2: latency=%0d, required 2", lat); else pass_cnt++;
    endtask

    task automatic test_mode_toggle();
        int lat; logic [15:0] d; logic o;
        // 7*5 - 2*3 = 29; mode_3x3 goes high after the first element
        mat_buf = '{7, 2, 3, 5, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b1, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h001D, 1'b0}) $display("FAIL det_mode_toggle: det=%h ovf=%b, required 001d 0", d, o); else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL lat_mode_toggle: latency=%0d, required 2", lat); else pass_cnt++;
        mode_3x3 = 1'b0;
    endtask

    task automatic test_overflow();
        int lat; logic [15:0] d; logic o;
        mat_buf = '{100, 0, 0, 0, 100, 0, 0, 0, 100};
        load_matrix(1'b1, 1'b1, 3, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h7FFF, 1'b1}) $display("FAIL sat_pos_3x3: det=%h ovf=%b, required 7fff 1", d, o); else pass_cnt++;
        mat_buf = '{-100, 0, 0, 0, 100, 0, 0, 0, 100};
        load_matrix(1'b1, 1'b1, 3, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h8000, 1'b1}) $display("FAIL sat_neg_3x3: det=%h ovf=%b, required 8000 1", d, o); else pass_cnt++;
        mat_buf = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        load_matrix(1'b1, 1'b1, 3, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h0001, 1'b0}) $display("FAIL identity_after_sat: det=%h ovf=%b, required 0001 0", d, o); else pass_cnt++;
        // edges of the 16-bit range
        mat_buf = '{32767, 0, 0, 1, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h7FFF, 1'b0}) $display("FAIL edge_max: det=%h ovf=%b, required 7fff 0", d, o); else pass_cnt++;
        mat_buf = '{128, 0, 0, 256, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h7FFF, 1'b1}) $display("FAIL edge_max_plus1: det=%h ovf=%b, required 7fff 1", d, o); else pass_cnt++;
        mat_buf = '{-32768, 0, 0, 1, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h8000, 1'b0}) $display("FAIL edge_min: det=%h ovf=%b, required 8000 0", d, o); else pass_cnt++;
        mat_buf = '{-32768, 1, 1, 1, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h8000, 1'b1}) $display("FAIL edge_min_minus1: det=%h ovf=%b, required 8000 1", d, o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int guard;
        // 1*(50-48) - 2*(40-42) + 3*(32-35) = -3
        mat_buf = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        det_ready = 1'b0;
        load_matrix(1'b1, 1'b1, 3, 0);
        guard = 0;
        while (det_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({det, overflow, det_valid, in_ready} !== {16'hFFFD, 1'b0, 1'b1, 1'b0})
                $display("FAIL hold_%0d: det=%h ovf=%b dv=%b rdy=%b, required fffd 0 1 0",
                         i, det, overflow, det_valid, in_ready);
            else pass_cnt++;
        end
        det_ready = 1'b1;
        @(negedge clk);
        det_ready = 1'b0;
        total_cnt++;
        if ({det_valid, in_ready, det} !== {1'b0, 1'b1, 16'hFFFD})
            $display("FAIL release: dv=%b rdy=%b det=%h, required 0 1 fffd", det_valid, in_ready, det);
        else pass_cnt++;
    endtask

    task automatic test_abort_load();
        int lat; logic [15:0] d; logic o;
        for (int i = 0; i < 4; i++) send_one(16'(i + 11), 1'b1, 2);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL partial_busy: busy=%b, required 1", busy); else pass_cnt++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total_cnt++;
        if ({busy, in_ready, det_valid} !== 3'b010) $display("FAIL abort_load: busy=%b rdy=%b dv=%b, required 0 1 0", busy, in_ready, det_valid);
        else pass_cnt++;
        // element presented together with abort must be dropped
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd99;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_with_valid: busy=%b, required 0", busy); else pass_cnt++;
        mat_buf = '{5, 0, 0, 0, 5, 0, 0, 0, 5};
        load_matrix(1'b1, 1'b1, 3, 2);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h007D, 1'b0}) $display("FAIL det_after_abort: det=%h ovf=%b, required 007d 0", d, o); else pass_cnt++;
        total_cnt++;
        if (lat !== 6) $display("FAIL lat_after_abort: latency=%0d, required 6", lat); else pass_cnt++;
    endtask

    task automatic test_abort_out();
        int guard;
        int lat; logic [15:0] d; logic o;
        mat_buf = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        load_matrix(1'b1, 1'b1, 3, 0);
        guard = 0;
        while (det_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        abort     = 1'b1;
        det_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        det_ready = 1'b0;
        total_cnt++;
        if ({det_valid, overflow, in_ready, det} !== {1'b0, 1'b0, 1'b1, 16'h0018})
            $display("FAIL abort_out: dv=%b ovf=%b rdy=%b det=%h, required 0 0 1 0018", det_valid, overflow, in_ready, det);
        else pass_cnt++;
        mat_buf = '{3, 0, 0, 0, 1, 0, 0, 0, 1};
        load_matrix(1'b1, 1'b1, 3, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'h0003, 1'b0}) $display("FAIL det_after_abort_out: det=%h ovf=%b, required 0003 0", d, o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        int lat; logic [15:0] d; logic o;
        mat_buf = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        load_matrix(1'b1, 1'b1, 3, 0);
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (dbg_state !== 2'd1) $display("FAIL pre_reset_state: state=%0d, required 1", dbg_state); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({det, det_valid, overflow, busy, in_ready, dbg_state} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0})
            $display("FAIL reset_mid_calc: det=%h dv=%b ovf=%b busy=%b rdy=%b st=%0d, required 0000 0 0 0 1 0",
                     det, det_valid, overflow, busy, in_ready, dbg_state);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        mat_buf = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
        load_matrix(1'b1, 1'b1, 3, 0);
        get_result(lat, d, o);
        total_cnt++;
        if ({d, o} !== {16'hFECE, 1'b0}) $display("FAIL det_after_reset: det=%h ovf=%b, required fece 0", d, o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] d; logic o;
        det_ready = 1'b1;
        mat_buf = '{3, 8, 4, 6, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        det_ready = 1'b1;
        mat_buf = '{-4, 2, 5, 1, 0, 0, 0, 0, 0};
        load_matrix(1'b0, 1'b0, 2, 0);
        get_result(lat, d, o);
        // -4*1 - 2*5 = -14
        total_cnt++;
        if ({d, o, lat} !== {16'hFFF2, 1'b0, 32'd2}) $display("FAIL back_to_back: det=%h ovf=%b lat=%0d, required fff2 0 2", d, o, lat);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        mode_3x3  = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        abort     = 1'b0;
        det_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_3x3_basic();
        test_2x2();
        test_mode_toggle();
        test_overflow();
        test_backpressure();
        test_abort_load();
        test_abort_out();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
